// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: buffers fetched {instr, addr} pairs in FIFO
// order between the fetch unit and decode, with a single-cycle flush that
// drops all wrong-path entries after a taken redirect.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 30,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_addr,
  input  logic          flush,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   instr_mem_r [DEPTH];
  logic [AW-1:0] addr_mem_r  [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;

  // Handshake qualifiers are derived from registered occupancy only, so
  // in_ready never depends combinationally on out_ready.
  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == {CW{1'b0}});
  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign push_s    = in_valid && !full_s;
  assign pop_s     = out_ready && !empty_s;

  // Head entry is read straight from the register array; no bypass from in_*.
  assign out_instr = instr_mem_r[rd_ptr_r];
  assign out_addr  = addr_mem_r[rd_ptr_r];
  assign count     = count_r;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and occupancy state; flush overrides any push/pop in its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      // DEPTH is a power of two, so natural overflow gives the wrap.
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage: cleared on reset, written on an accepted push unless flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= 32'h0000_0000;
        addr_mem_r[i]  <= {AW{1'b0}};
      end
    end else if (push_s && !flush) begin
      instr_mem_r[wr_ptr_r] <= in_instr;
      addr_mem_r[wr_ptr_r]  <= in_addr;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= instr_mem_r[i];
        addr_mem_r[i]  <= addr_mem_r[i];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4, AW=30).
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_instr;
  logic [AW-1:0] in_addr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          flush;
  logic [CW-1:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ei, input logic [AW-1:0] ea);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_instr"}, 64'(out_instr), 64'(ei));
    chk({tag, "_addr"},  64'(out_addr),  64'(ea));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_addr = '0;
    out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ---- fill ----
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'hA000_0000 + 32'(i); in_addr = AW'(i);
      tick();
      if (i == 0) chk_head("latency", 32'hA000_0000, AW'(0));
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_instr = 32'hBBBB_BBBB; in_addr = AW'(9);
    tick();
    in_valid = 1'b0;
    chk("push_full_count", 64'(count), 64'd4);
    chk_head("push_full_head", 32'hA000_0000, AW'(0));

    // ---- drain ----
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head("drain", 32'hA000_0000 + 32'(i), AW'(i));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    out_ready = 1'b0;

    // ---- simultaneous push/pop at count 2 ----
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = 32'hC000_0000 + 32'(i); in_addr = AW'(16 + i);
      tick();
    end
    chk("pp_pre_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_instr = 32'hC000_0002 + 32'(k); in_addr = AW'(18 + k);
      chk_head("pp_head", 32'hC000_0000 + 32'(k), AW'(16 + k));
      tick();
      chk("pp_count", 64'(count), 64'd2);
    end
    out_ready = 1'b0;
    in_instr = 32'hC000_000C; in_addr = AW'(28);
    tick();
    in_valid = 1'b0;
    chk("pp_post_count", 64'(count), 64'd3);
    chk_head("pp_post_head", 32'hC000_000A, AW'(26));

    // ---- flush with concurrent push and pop ----
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; in_addr = AW'(63);
    out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_instr = 32'h1234_5678; in_addr = AW'(64);
    tick();
    in_valid = 1'b0;
    chk("post_flush_count", 64'(count), 64'd1);
    chk_head("post_flush", 32'h1234_5678, AW'(64));
    out_ready = 1'b1;
    tick();
    chk("post_flush_drained", 64'(out_valid), 64'd0);

    // ---- pop while empty ----
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty_pop_count", 64'(count), 64'd0);
      chk("empty_pop_valid", 64'(out_valid), 64'd0);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h55AA_0001; in_addr = AW'(291);
    tick();
    in_valid = 1'b0;
    chk_head("after_empty_pop", 32'h55AA_0001, AW'(291));

    // ---- full with pop ----
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_instr = 32'h6600_0000 + 32'(i); in_addr = AW'(512 + i);
      tick();
    end
    chk("fwp_full", 64'(count), 64'd4);
    in_instr = 32'h7700_0000; in_addr = AW'(768); out_ready = 1'b1;
    tick();
    chk("fwp_edge1_count", 64'(count), 64'd3);
    chk_head("fwp_edge1", 32'h6600_0001, AW'(513));
    tick();
    in_valid = 1'b0;
    chk("fwp_edge2_count", 64'(count), 64'd3);
    chk_head("fwp_edge2", 32'h6600_0002, AW'(514));
    tick();
    chk_head("fwp_drain1", 32'h6600_0003, AW'(515));
    tick();
    chk_head("fwp_drain2", 32'h7700_0000, AW'(768));
    tick();
    chk("fwp_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // ---- asynchronous reset mid-cycle with 3 entries held ----
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = 32'h8800_0000 + 32'(i + 1); in_addr = AW'(100 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_instr", 64'(out_instr), 64'd0);
    chk("arst_out_addr", 64'(out_addr), 64'd0);
    #1;
    reset = 1'b0;
    tick();
    chk("post_rst_count", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
